// File: rtl/fft_stream_io.sv
// fft_stream_io
//   Streams one frame of N = 4*2^ADDR_W real samples into a four-bank FFT
//   core, pulses its start, waits for the core's done flag, then reads the
//   four banks back row by row and presents the results on a valid/ready
//   output stream in natural order (result k = bank k%4, address k>>2).
//
// Ports
//   iCLK, iRESET          clock (rising edge), async active-low reset
//   iS_VALID/iS_DATA      input sample stream; oS_READY high only in LOAD
//   oFFT_DATA/ADDR_WR/WE  combinational write path into the core banks
//   oFFT_ADDR_RD          common read address for the four banks
//   oFFT_START            one-cycle start pulse
//   iFFT_RDY              core done level (rising edge is acted upon)
//   iFFT_RE_0..3          bank read data, one cycle after the address
//   oM_VALID/DATA/LAST    output result stream, iM_READY backpressure
//   oBUSY                 high whenever not loading
module fft_stream_io #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic                     iS_VALID,
  input  logic signed [DATA_W-1:0] iS_DATA,
  output logic                     oS_READY,
  output logic [DATA_W-1:0]        oFFT_DATA,
  output logic [ADDR_W-1:0]        oFFT_ADDR_WR,
  output logic [3:0]               oFFT_WE,
  output logic [ADDR_W-1:0]        oFFT_ADDR_RD,
  output logic                     oFFT_START,
  input  logic                     iFFT_RDY,
  input  logic [DATA_W:0]          iFFT_RE_0,
  input  logic [DATA_W:0]          iFFT_RE_1,
  input  logic [DATA_W:0]          iFFT_RE_2,
  input  logic [DATA_W:0]          iFFT_RE_3,
  output logic                     oM_VALID,
  output logic [DATA_W:0]          oM_DATA,
  output logic                     oM_LAST,
  input  logic                     iM_READY,
  output logic                     oBUSY
);

  localparam int CNT_W = ADDR_W + 2;

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_CALC,
    S_RD_ADDR,
    S_RD_CAP,
    S_SEND
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [ADDR_W-1:0]  row_q, row_d;
  logic [1:0]         lane_q, lane_d;
  logic               rdy_q;
  logic [DATA_W:0]    buf_q [4];
  logic [DATA_W:0]    buf_d [4];

  logic               in_xfer;
  logic               last_word;
  logic [3:0]         we;

  assign in_xfer   = iS_VALID && (state_q == S_LOAD);
  assign last_word = (state_q == S_SEND) && (&row_q) && (lane_q == 2'd3);

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    row_d    = row_q;
    lane_d   = lane_q;
    buf_d    = buf_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_xfer) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (&in_cnt_q) state_d = S_START;
        end
      end
      S_START: state_d = S_CALC;
      // rdy_q tracks the done flag every cycle, so a level that was already
      // high when CALC is entered does not look like an edge.
      S_CALC: begin
        if (iFFT_RDY && !rdy_q) state_d = S_RD_ADDR;
      end
      S_RD_ADDR: state_d = S_RD_CAP;
      S_RD_CAP: begin
        buf_d[0] = iFFT_RE_0;
        buf_d[1] = iFFT_RE_1;
        buf_d[2] = iFFT_RE_2;
        buf_d[3] = iFFT_RE_3;
        lane_d   = 2'd0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (iM_READY) begin
          if (lane_q == 2'd3) begin
            if (last_word) begin
              row_d   = '0;
              state_d = S_LOAD;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = S_RD_ADDR;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q  <= S_LOAD;
      in_cnt_q <= '0;
      row_q    <= '0;
      lane_q   <= '0;
      rdy_q    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      row_q    <= row_d;
      lane_q   <= lane_d;
      rdy_q    <= iFFT_RDY;
      buf_q    <= buf_d;
    end
  end

  // Write enable is gated by reset so nothing reaches the banks while the
  // block is held in reset, even though the state already reads LOAD.
  always_comb begin
    we = '0;
    if (in_xfer && iRESET) we[in_cnt_q[1:0]] = 1'b1;
  end

  assign oS_READY     = (state_q == S_LOAD);
  assign oFFT_DATA    = iS_DATA;
  assign oFFT_ADDR_WR = in_cnt_q[CNT_W-1:2];
  assign oFFT_WE      = we;
  assign oFFT_ADDR_RD = row_q;
  assign oFFT_START   = (state_q == S_START);
  assign oM_VALID     = (state_q == S_SEND);
  assign oM_DATA      = buf_q[lane_q];
  assign oM_LAST      = last_word;
  assign oBUSY        = (state_q != S_LOAD);

endmodule

// File: doc/fft_stream_io.md
FFT_STREAM_IO -- requirements
Module: fft_stream_io

Interface
REQ-001 Parameters SHALL be ADDR_W, default 9, per-bank address width; and DATA_W, default 16, input sample width. Frame length is N = 4*2^ADDR_W (2048 by default).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named per codebase convention as iCLK and iRESET.
REQ-003 The ports SHALL be as follows, one per line:
- iCLK  in  1  clock, rising edge.
- iRESET  in  1  asynchronous active-low reset.
- iS_VALID  in  1  input sample valid.
- iS_DATA  in  DATA_W  input sample, signed, real part.
- oS_READY  out  1  block accepts an input sample.
- oFFT_DATA  out  DATA_W  write data to the FFT core's iDATA.
- oFFT_ADDR_WR  out  ADDR_W  write address, common to all four banks.
- oFFT_WE  out  4  per-bank write enables; bit k drives iWE_k.
- oFFT_ADDR_RD  out  ADDR_W  read address, common to all four banks.
- oFFT_START  out  1  one-cycle start pulse to the core.
- iFFT_RDY  in  1  core done flag (level).
- iFFT_RE_0 .. iFFT_RE_3  in  DATA_W+1 each  bank read data, valid 1 cycle after the address.
- oM_VALID  out  1  output result valid.
- oM_DATA  out  DATA_W+1  output result, real part.
- oM_LAST  out  1  marks the final result of the frame.
- iM_READY  in  1  downstream accepts a result.
- oBUSY  out  1  high in any state except LOAD.

Function
REQ-004 The FSM SHALL have the states LOAD, START, CALC, RD_ADDR, RD_CAP and SEND.
REQ-005 In LOAD, oS_READY SHALL be 1, and an input transfer occurs on iS_VALID && oS_READY.
REQ-006 Input transfer n (0..N-1) SHALL drive oFFT_DATA=iS_DATA, oFFT_ADDR_WR=n>>2 and oFFT_WE=one-hot(n[1:0]), combinationally in the same cycle; otherwise oFFT_WE=0.
REQ-007 When the input transfer with n=N-1 occurs, the FSM SHALL go to START and the input counter SHALL wrap to 0.
REQ-008 START SHALL last exactly one cycle with oFFT_START=1, then go to CALC; oFFT_START SHALL be 0 in all other states.
REQ-009 CALC SHALL register iFFT_RDY and go to RD_ADDR on its rising edge (previous 0, current 1); a level already high on CALC entry SHALL NOT trigger the transition.
REQ-010 RD_ADDR SHALL drive oFFT_ADDR_RD=row (row counter 0..2^ADDR_W-1) for one cycle, then go to RD_CAP.
REQ-011 RD_CAP SHALL capture iFFT_RE_0..3 into a 4-word buffer, then go to SEND with lane index 0.
REQ-012 SEND SHALL present oM_VALID=1 and oM_DATA=buffer[lane]; the lane SHALL advance only on oM_VALID && iM_READY.
REQ-013 oM_VALID, oM_DATA and oM_LAST SHALL hold stable while iM_READY=0.
REQ-014 oM_LAST SHALL be 1 only when row=2^ADDR_W-1 and lane=3.
REQ-015 After lane 3 is accepted, the row counter SHALL increment and the FSM SHALL go to RD_ADDR; if the accepted word carried oM_LAST, the FSM SHALL instead go to LOAD with the row counter at 0.
REQ-016 Output order SHALL be result k = bank k%4, address k>>2, for k = 0..N-1.
REQ-017 iS_VALID outside LOAD SHALL be ignored (oS_READY=0); no write SHALL occur and no sample SHALL be counted.
REQ-018 The data path SHALL NOT change the width or value of any word: each result is passed through unchanged, with no truncation.

Reset
REQ-019 While iRESET=0, the state SHALL be LOAD, all counters 0 and the buffer 0.
REQ-020 While iRESET=0, the outputs SHALL be: oS_READY=1, oFFT_WE=0, oFFT_START=0, oM_VALID=0, oM_LAST=0, oBUSY=0, and oFFT_ADDR_WR, oFFT_ADDR_RD and oM_DATA all 0.
REQ-021 Reset asserted in any state, including mid-frame or mid-SEND, SHALL discard the partial frame; after release, the next accepted sample is n=0.

Verification
REQ-022 Load ramp: N samples 0..N-1 with iS_VALID held high -> sample 5 writes oFFT_WE=4'b0010 at address 1; sample 2047 writes oFFT_WE=4'b1000 at address 511; the next cycle has oFFT_START=1 for 1 cycle and oBUSY=1.
REQ-023 Done detection: iFFT_RDY held 1 before START, then dropped and raised 20 cycles later -> no read before the rise; oFFT_ADDR_RD=0 in the cycle after the rising edge is sampled.
REQ-024 Unload with a bank model returning bank*1000+addr -> the output sequence is 0, 1000, 2000, 3000, 1, 1001, ...; oM_LAST=1 only on value 3511; the block returns to LOAD with oS_READY=1.
REQ-025 Backpressure: iM_READY toggling at random (~50%) -> no output word lost or duplicated, and oM_DATA is stable while stalled.
REQ-026 Reset mid-load after 1000 samples, then a full new frame -> the first write after release is at address 0, bank 0.
REQ-027 Reset during SEND -> oM_VALID=0 immediately (asynchronous); after release, state LOAD.
